// File: rtl/cc_pkg.sv
// -----------------------------------------------------------------------------
// cc_pkg
//  Shared constants and types for the cache-controller read-data return path.
//  - CC_LINE_WIDTH / CC_DATA_WIDTH / CC_BEATS : line, R-beat and burst geometry
//  - CC_WORD_IDX_W : width of a beat index within a line
//  - CC_OFFSET_W   : width of a byte offset within a line
//  - cc_ser_state_t: serializer control states
// -----------------------------------------------------------------------------
package cc_pkg;

   localparam int CC_LINE_WIDTH = 512;
   localparam int CC_DATA_WIDTH = 64;
   localparam int CC_BEATS      = CC_LINE_WIDTH / CC_DATA_WIDTH;
   localparam int CC_WORD_IDX_W = $clog2(CC_BEATS);
   localparam int CC_OFFSET_W   = $clog2(CC_LINE_WIDTH / 8);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } cc_ser_state_t;

endpackage : cc_pkg

// File: rtl/cc_serializer.sv
// -----------------------------------------------------------------------------
// cc_serializer
//  Read-data return path of the cache controller. Pops one cache line (plus the
//  byte offset of the request that fetched it) from a show-ahead line FIFO and
//  returns it as a full-length AXI R burst, critical word first, wrapping
//  inside the line. Back-to-back lines are sent without a bubble.
//
//  Ports
//   clk            clock
//   rst_n          asynchronous reset, active low
//   fifo_empty_i   line FIFO empty
//   fifo_rdata_i   line FIFO head data (valid while !fifo_empty_i)
//   fifo_offset_i  byte offset of the request that owns the head line
//   fifo_rden_o    FIFO pop, one-cycle pulse
//   inct_rdata_o   R data beat
//   inct_rvalid_o  R valid
//   inct_rlast_o   last beat of the burst
//   inct_rready_i  R ready from the interconnect
// -----------------------------------------------------------------------------
module cc_serializer
   import cc_pkg::*;
#(
   parameter int LINE_WIDTH = CC_LINE_WIDTH,
   parameter int DATA_WIDTH = CC_DATA_WIDTH,
   parameter int BEATS      = CC_BEATS
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              fifo_empty_i,
   input  logic [LINE_WIDTH-1:0]             fifo_rdata_i,
   input  logic [$clog2(LINE_WIDTH/8)-1:0]   fifo_offset_i,
   output logic                              fifo_rden_o,
   output logic [DATA_WIDTH-1:0]             inct_rdata_o,
   output logic                              inct_rvalid_o,
   output logic                              inct_rlast_o,
   input  logic                              inct_rready_i
);

   localparam int IDX_W  = $clog2(BEATS);
   localparam int LANE_W = $clog2(DATA_WIDTH / 8);
   localparam int OFF_W  = $clog2(LINE_WIDTH / 8);

   cc_ser_state_t         state;
   logic [LINE_WIDTH-1:0] line;
   logic [IDX_W-1:0]      start_word;
   logic [IDX_W-1:0]      beat_cnt;
   logic [IDX_W-1:0]      word_idx;

   logic handshake;
   logic last_beat;
   logic pop;

   // Byte-lane bits of the offset do not matter: bursts are beat aligned.
   logic unused_lane_bits;
   assign unused_lane_bits = ^fifo_offset_i[LANE_W-1:0];

   // ---- control / handshake ------------------------------------------------
   assign inct_rvalid_o = (state == S_SEND);
   assign last_beat     = (beat_cnt == IDX_W'(BEATS - 1));
   assign inct_rlast_o  = inct_rvalid_o && last_beat;
   assign handshake     = inct_rvalid_o && inct_rready_i;

   // A pop happens from IDLE, or on the last-beat handshake so the next line
   // follows without a bubble. Gated by rst_n so nothing is popped while the
   // block is held in reset.
   assign pop = rst_n && !fifo_empty_i &&
                ((state == S_IDLE) || (handshake && last_beat));
   assign fifo_rden_o = pop;

   // ---- word select --------------------------------------------------------
   // Index arithmetic wraps naturally at IDX_W bits, giving the wrap within
   // the line starting at the critical word.
   assign word_idx     = start_word + beat_cnt;
   assign inct_rdata_o = inct_rvalid_o ? line[word_idx*DATA_WIDTH +: DATA_WIDTH]
                                       : '0;

   // ---- state / line registers ---------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         line       <= '0;
         start_word <= '0;
         beat_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  line       <= fifo_rdata_i;
                  start_word <= fifo_offset_i[OFF_W-1:LANE_W];
                  beat_cnt   <= '0;
                  state      <= S_SEND;
               end
            end
            S_SEND: begin
               if (handshake) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     if (pop) begin
                        line       <= fifo_rdata_i;
                        start_word <= fifo_offset_i[OFF_W-1:LANE_W];
                     end else begin
                        state <= S_IDLE;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + IDX_W'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : cc_serializer

// File: tb/tb_cc_serializer.sv
// -----------------------------------------------------------------------------
// tb_cc_serializer
//  Self-checking bench for cc_serializer. A queue models the show-ahead line
//  FIFO; every pushed line also appends its expected R beats (critical word
//  first, wrapping) to an expected-beat queue. A negedge collector records
//  accepted beats and pops with their cycle numbers; each test compares them.
// -----------------------------------------------------------------------------
module tb_cc_serializer;
   import cc_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         fifo_empty_i = 1'b1;
   logic [511:0] fifo_rdata_i = '0;
   logic [5:0]   fifo_offset_i = '0;
   logic         fifo_rden_o;
   logic [63:0]  inct_rdata_o;
   logic         inct_rvalid_o;
   logic         inct_rlast_o;
   logic         inct_rready_i = 1'b0;

   always #5 clk = ~clk;

   cc_serializer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_rdata_i  (fifo_rdata_i),
      .fifo_offset_i (fifo_offset_i),
      .fifo_rden_o   (fifo_rden_o),
      .inct_rdata_o  (inct_rdata_o),
      .inct_rvalid_o (inct_rvalid_o),
      .inct_rlast_o  (inct_rlast_o),
      .inct_rready_i (inct_rready_i)
   );

   typedef struct {
      logic [511:0] line;
      logic [5:0]   off;
   } ent_t;

   ent_t        fq[$];
   logic [63:0] exp_data[$];
   logic        exp_last[$];
   logic [63:0] obs_data[$];
   logic        obs_last[$];
   int          obs_cyc[$];
   int          pop_cyc[$];
   int          cyc = 0;
   int          bad_pops = 0;
   int          checks = 0;
   int          errors = 0;

   // Line FIFO model: pop on rden, present the new head after the edge.
   always @(posedge clk) begin
      if (fifo_rden_o && rst_n) begin
         if (fq.size() == 0) bad_pops <= bad_pops + 1;
         else fq.delete(0);
      end
      if (fq.size() == 0) begin
         fifo_empty_i  <= 1'b1;
         fifo_rdata_i  <= '0;
         fifo_offset_i <= '0;
      end else begin
         fifo_empty_i  <= 1'b0;
         fifo_rdata_i  <= fq[0].line;
         fifo_offset_i <= fq[0].off;
      end
   end

   // Collector: inputs only change just after posedge, so what is seen at the
   // negedge is what the next posedge commits.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (inct_rvalid_o && inct_rready_i) begin
            obs_data.push_back(inct_rdata_o);
            obs_last.push_back(inct_rlast_o);
            obs_cyc.push_back(cyc);
         end
         if (fifo_rden_o) pop_cyc.push_back(cyc);
      end
   end

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom();
      return l;
   endfunction

   // Reference: beat k carries word ((offset / 8) + k) mod 8.
   task automatic push_line(input logic [511:0] l, input logic [5:0] off);
      ent_t e;
      int   w;
      e.line = l;
      e.off  = off;
      fq.push_back(e);
      for (int k = 0; k < 8; k++) begin
         w = ((int'(off) / 8) + k) % 8;
         exp_data.push_back(l[64*w +: 64]);
         exp_last.push_back(k == 7);
      end
   endtask

   task automatic clear_queues();
      fq.delete();
      exp_data.delete();
      exp_last.delete();
      obs_data.delete();
      obs_last.delete();
      obs_cyc.delete();
      pop_cyc.delete();
   endtask

   task automatic do_reset();
      inct_rready_i = 1'b0;
      rst_n = 1'b0;
      clear_queues();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_beats(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #1;
         if (obs_data.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({inct_rvalid_o, inct_rlast_o, fifo_rden_o} !== 3'b000 || inct_rdata_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_initial: got v/l/rden=%b%b%b data=%h required 000 data=0", inct_rvalid_o, inct_rlast_o, fifo_rden_o, inct_rdata_o);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      inct_rready_i = 1'b1;
      push_line(rand_line(), 6'h10);
      push_line(rand_line(), 6'h00);
      wait_beats(1, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_first_beat: got no beat within 20 cycles required a beat");
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      // The second line is still at the FIFO head here, so rden must be held low.
      checks++;
      if ({inct_rvalid_o, inct_rlast_o, fifo_rden_o} !== 3'b000 || inct_rdata_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_async: got v/l/rden=%b%b%b data=%h required 000 data=0", inct_rvalid_o, inct_rlast_o, fifo_rden_o, inct_rdata_o);
      end
      clear_queues();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (inct_rvalid_o !== 1'b0 || fifo_rden_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_empty: got rvalid=%b rden=%b required 0 0", inct_rvalid_o, fifo_rden_o);
         end
      end
   endtask

   task automatic test_in_order();
      bit ok;
      logic [511:0] l;
      do_reset();
      inct_rready_i = 1'b1;
      for (int i = 0; i < 8; i++) l[64*i +: 64] = {32'hC0DE_0000, 32'(i)};
      push_line(l, 6'h00);
      wait_beats(8, 40, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_data.size() != 8 || pop_cyc.size() != 1) begin
         errors++;
         $display("FAIL inorder_counts: got beats=%0d pops=%0d required 8 1", obs_data.size(), pop_cyc.size());
      end
      for (int k = 0; k < obs_data.size() && k < 8; k++) begin
         checks++;
         if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k] || obs_cyc[k] != obs_cyc[0] + k) begin
            errors++;
            $display("FAIL inorder_beat%0d: got %h last=%b cyc=%0d required %h last=%b cyc=%0d", k, obs_data[k], obs_last[k], obs_cyc[k], exp_data[k], exp_last[k], obs_cyc[0] + k);
         end
      end
      if (obs_cyc.size() > 0 && pop_cyc.size() > 0) begin
         checks++;
         if (obs_cyc[0] != pop_cyc[0] + 1) begin
            errors++;
            $display("FAIL inorder_latency: got %0d cycles required 1", obs_cyc[0] - pop_cyc[0]);
         end
      end
   endtask

   task automatic test_wrap_offset();
      bit ok;
      logic [5:0] offs [2];
      offs[0] = 6'h28;
      offs[1] = 6'h2F;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         inct_rready_i = 1'b1;
         push_line(rand_line(), offs[t]);
         wait_beats(8, 40, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL wrap_timeout_off%h: got %0d beats required 8", offs[t], obs_data.size());
         end
         for (int k = 0; k < obs_data.size() && k < 8; k++) begin
            checks++;
            if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
               errors++;
               $display("FAIL wrap_off%h_beat%0d: got %h last=%b required %h last=%b", offs[t], k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      do_reset();
      inct_rready_i = 1'b1;
      push_line(rand_line(), 6'h18);
      wait_beats(2, 40, ok);
      @(posedge clk);
      #1 inct_rready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (inct_rvalid_o !== 1'b1 || inct_rdata_o !== exp_data[2] || inct_rlast_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold_c%0d: got v=%b %h l=%b required v=1 %h l=0", c, inct_rvalid_o, inct_rdata_o, inct_rlast_o, exp_data[2]);
         end
      end
      @(posedge clk);
      #1 inct_rready_i = 1'b1;
      wait_beats(8, 40, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_data.size() != 8) begin
         errors++;
         $display("FAIL stall_count: got %0d beats required 8", obs_data.size());
      end
      for (int k = 0; k < obs_data.size() && k < 8; k++) begin
         checks++;
         if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
            errors++;
            $display("FAIL stall_beat%0d: got %h last=%b required %h last=%b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      inct_rready_i = 1'b1;
      push_line(rand_line(), 6'h08);
      push_line(rand_line(), 6'h38);
      wait_beats(16, 60, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_data.size() != 16 || pop_cyc.size() != 2) begin
         errors++;
         $display("FAIL b2b_counts: got beats=%0d pops=%0d required 16 2", obs_data.size(), pop_cyc.size());
      end
      for (int k = 0; k < obs_data.size() && k < 16; k++) begin
         checks++;
         if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k] || obs_cyc[k] != obs_cyc[0] + k) begin
            errors++;
            $display("FAIL b2b_beat%0d: got %h last=%b cyc=%0d required %h last=%b cyc=%0d", k, obs_data[k], obs_last[k], obs_cyc[k], exp_data[k], exp_last[k], obs_cyc[0] + k);
         end
      end
      if (obs_cyc.size() >= 8 && pop_cyc.size() >= 2) begin
         checks++;
         if (pop_cyc[1] != obs_cyc[7]) begin
            errors++;
            $display("FAIL b2b_second_pop: got cycle %0d required %0d", pop_cyc[1], obs_cyc[7]);
         end
      end
   endtask

   task automatic test_reset_midburst();
      bit ok;
      do_reset();
      inct_rready_i = 1'b1;
      push_line(rand_line(), 6'h20);
      wait_beats(4, 40, ok);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({inct_rvalid_o, inct_rlast_o, fifo_rden_o} !== 3'b000 || inct_rdata_o !== 64'h0) begin
         errors++;
         $display("FAIL midburst_reset: got v/l/rden=%b%b%b data=%h required 000 data=0", inct_rvalid_o, inct_rlast_o, fifo_rden_o, inct_rdata_o);
      end
      clear_queues();
      push_line(rand_line(), 6'h30);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_beats(8, 40, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_data.size() != 8) begin
         errors++;
         $display("FAIL midburst_restart_count: got %0d beats required 8", obs_data.size());
      end
      for (int k = 0; k < obs_data.size() && k < 8; k++) begin
         checks++;
         if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
            errors++;
            $display("FAIL midburst_restart_beat%0d: got %h last=%b required %h last=%b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
         end
      end
   endtask

   task automatic test_random();
      logic        prev_stall;
      logic [63:0] prev_data;
      logic        prev_last;
      int          c;
      do_reset();
      for (int i = 0; i < 6; i++) push_line(rand_line(), 6'($urandom_range(0, 63)));
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      c = 0;
      while (obs_data.size() < 48 && c < 600) begin
         @(posedge clk);
         #1 inct_rready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         #1;
         if (prev_stall) begin
            checks++;
            if (inct_rvalid_o !== 1'b1 || inct_rdata_o !== prev_data || inct_rlast_o !== prev_last) begin
               errors++;
               $display("FAIL rand_hold: got v=%b %h l=%b required v=1 %h l=%b", inct_rvalid_o, inct_rdata_o, inct_rlast_o, prev_data, prev_last);
            end
         end
         prev_stall = inct_rvalid_o && !inct_rready_i;
         prev_data  = inct_rdata_o;
         prev_last  = inct_rlast_o;
         c++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (obs_data.size() != 48 || pop_cyc.size() != 6) begin
         errors++;
         $display("FAIL rand_counts: got beats=%0d pops=%0d required 48 6", obs_data.size(), pop_cyc.size());
      end
      for (int k = 0; k < obs_data.size() && k < 48; k++) begin
         checks++;
         if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
            errors++;
            $display("FAIL rand_beat%0d: got %h last=%b required %h last=%b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
         end
      end
      checks++;
      if (bad_pops != 0) begin
         errors++;
         $display("FAIL pop_when_empty: got %0d pops required 0", bad_pops);
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_wrap_offset();
      test_backpressure();
      test_back_to_back();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cc_serializer
